// File: rtl/l4_route_ctrl_if.sv
// rtl/l4_route_ctrl_if.sv - request/status/array-control bundle for the L4 route controller
interface l4_route_ctrl_if #(
   parameter int NRBITS = 5,
   parameter int NCBITS = 5,
   parameter int NSBITS = 10
);
   logic              start;
   logic              abort;
   logic [NRBITS-1:0] src_row;
   logic [NCBITS-1:0] src_col;
   logic [NRBITS-1:0] tgt_row;
   logic [NCBITS-1:0] tgt_col;
   logic [3:0]        status_out;
   logic [2:0]        row_range_sel;
   logic [NRBITS-1:0] row_l_v;
   logic [NRBITS-1:0] row_u_v;
   logic [2:0]        col_range_sel;
   logic [NCBITS-1:0] col_l_v;
   logic [NCBITS-1:0] col_u_v;
   logic [1:0]        cell_cmd;
   logic              extend;
   logic              ret2ue;
   logic              etch_enb;
   logic              busy;
   logic              done;
   logic              found;
   logic [NSBITS-1:0] step_count;

   modport master (
      input  start, abort, src_row, src_col, tgt_row, tgt_col, status_out,
      output row_range_sel, row_l_v, row_u_v, col_range_sel, col_l_v, col_u_v,
             cell_cmd, extend, ret2ue, etch_enb, busy, done, found, step_count
   );

   modport slave (
      output start, abort, src_row, src_col, tgt_row, tgt_col, status_out,
      input  row_range_sel, row_l_v, row_u_v, col_range_sel, col_l_v, col_u_v,
             cell_cmd, extend, ret2ue, etch_enb, busy, done, found, step_count
   );
endinterface

// File: rtl/l4_route_ctrl.sv
// rtl/l4_route_ctrl.sv - five-phase route sequencer (clear, mark, expand, trace, etch) for the L4 array
module l4_route_ctrl #(
   parameter int         NRBITS   = 5,
   parameter int         NCBITS   = 5,
   parameter int         NSBITS   = 10,
   parameter int         MAXSTEPS = 1000,
   parameter logic [1:0] CMD_CLR  = 2'b00,
   parameter logic [1:0] CMD_SRC  = 2'b01,
   parameter logic [1:0] CMD_TGT  = 2'b10,
   parameter logic [1:0] CMD_NOP  = 2'b11
) (
   input logic               clk,
   input logic               resetn,
   l4_route_ctrl_if.master   bus
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CLEAR, ST_MARK_SRC, ST_MARK_TGT, ST_EXPAND, ST_TRACE, ST_ETCH, ST_FIN
   } state_t;

   localparam logic [NSBITS-1:0] LP_LAST = NSBITS'(MAXSTEPS - 1);
   localparam logic [NSBITS-1:0] LP_MAX  = NSBITS'(MAXSTEPS);

   state_t            r_state, w_next;
   logic [2:0]        r_row_sel, r_col_sel, w_row_sel, w_col_sel;
   logic [NRBITS-1:0] r_row_l, r_row_u, w_row_l, w_row_u;
   logic [NCBITS-1:0] r_col_l, r_col_u, w_col_l, w_col_u;
   logic [1:0]        r_cmd, w_cmd;
   logic              r_extend, r_ret2ue, r_etch, r_busy, r_done, r_found;
   logic              w_extend, w_ret2ue, w_etch, w_busy, w_done, w_found;
   logic [NSBITS-1:0] r_step, r_trace, w_step, w_trace;

   // next state, counters and result flag; abort overrides every status-driven exit
   always_comb begin
      w_next  = r_state;
      w_step  = r_step;
      w_trace = r_trace;
      w_found = r_found;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_next  = ST_CLEAR;
               w_step  = '0;
               w_found = 1'b0;
            end
         end
         ST_CLEAR:    w_next = ST_MARK_SRC;
         ST_MARK_SRC: w_next = ST_MARK_TGT;
         ST_MARK_TGT: w_next = ST_EXPAND;
         ST_EXPAND: begin
            if (r_step != LP_MAX) w_step = r_step + 1'b1;
            if (bus.status_out[0]) begin
               w_next  = ST_TRACE;
               w_trace = '0;
            end else if (bus.status_out[1] || (r_step == LP_LAST)) begin
               w_next  = ST_FIN;
               w_found = 1'b0;
            end
         end
         ST_TRACE: begin
            if (r_trace != LP_MAX) w_trace = r_trace + 1'b1;
            if (bus.status_out[2]) begin
               w_next = ST_ETCH;
            end else if (r_trace == LP_LAST) begin
               w_next  = ST_FIN;
               w_found = 1'b0;
            end
         end
         ST_ETCH: begin
            w_next  = ST_FIN;
            w_found = 1'b1;
         end
         ST_FIN:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
      if (bus.abort && (r_state != ST_IDLE)) begin
         w_next  = ST_IDLE;
         w_step  = r_step;
         w_found = 1'b0;
      end
   end

   // array-side outputs are decoded from the next state so they line up with the registered state
   always_comb begin
      w_row_sel = 3'd0;
      w_col_sel = 3'd0;
      w_row_l   = '0;
      w_row_u   = '0;
      w_col_l   = '0;
      w_col_u   = '0;
      w_cmd     = CMD_NOP;
      w_extend  = 1'b0;
      w_ret2ue  = 1'b0;
      w_etch    = 1'b0;
      w_done    = 1'b0;
      w_busy    = (w_next != ST_IDLE);
      case (w_next)
         ST_CLEAR: begin
            w_row_sel = 3'd2;
            w_col_sel = 3'd2;
            w_cmd     = CMD_CLR;
         end
         ST_MARK_SRC: begin
            w_row_sel = 3'd1;
            w_col_sel = 3'd1;
            w_row_l   = bus.src_row;
            w_row_u   = bus.src_row;
            w_col_l   = bus.src_col;
            w_col_u   = bus.src_col;
            w_cmd     = CMD_SRC;
         end
         ST_MARK_TGT: begin
            w_row_sel = 3'd1;
            w_col_sel = 3'd1;
            w_row_l   = bus.tgt_row;
            w_row_u   = bus.tgt_row;
            w_col_l   = bus.tgt_col;
            w_col_u   = bus.tgt_col;
            w_cmd     = CMD_TGT;
         end
         ST_EXPAND: begin
            w_row_sel = 3'd2;
            w_col_sel = 3'd2;
            w_extend  = 1'b1;
         end
         ST_TRACE: begin
            w_row_sel = 3'd2;
            w_col_sel = 3'd2;
            w_ret2ue  = 1'b1;
         end
         ST_ETCH: begin
            w_row_sel = 3'd2;
            w_col_sel = 3'd2;
            w_etch    = 1'b1;
         end
         ST_FIN:  w_done = 1'b1;
         default: w_done = 1'b0;
      endcase
   end

   // state and every output register; reset leaves the array idle with a NOP command
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_row_sel <= 3'd0;
         r_col_sel <= 3'd0;
         r_row_l   <= '0;
         r_row_u   <= '0;
         r_col_l   <= '0;
         r_col_u   <= '0;
         r_cmd     <= CMD_NOP;
         r_extend  <= 1'b0;
         r_ret2ue  <= 1'b0;
         r_etch    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_found   <= 1'b0;
         r_step    <= '0;
         r_trace   <= '0;
      end else begin
         r_state   <= w_next;
         r_row_sel <= w_row_sel;
         r_col_sel <= w_col_sel;
         r_row_l   <= w_row_l;
         r_row_u   <= w_row_u;
         r_col_l   <= w_col_l;
         r_col_u   <= w_col_u;
         r_cmd     <= w_cmd;
         r_extend  <= w_extend;
         r_ret2ue  <= w_ret2ue;
         r_etch    <= w_etch;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_found   <= w_found;
         r_step    <= w_step;
         r_trace   <= w_trace;
      end
   end

   assign bus.row_range_sel = r_row_sel;
   assign bus.col_range_sel = r_col_sel;
   assign bus.row_l_v       = r_row_l;
   assign bus.row_u_v       = r_row_u;
   assign bus.col_l_v       = r_col_l;
   assign bus.col_u_v       = r_col_u;
   assign bus.cell_cmd      = r_cmd;
   assign bus.extend        = r_extend;
   assign bus.ret2ue        = r_ret2ue;
   assign bus.etch_enb      = r_etch;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.found         = r_found;
   assign bus.step_count    = r_step;

endmodule

// File: tb/tb_l4_route_ctrl.sv
// tb/tb_l4_route_ctrl.sv - directed bench with result scoreboard for l4_route_ctrl
module tb_l4_route_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start;
   logic       abort;
   logic       sel;
   logic [5:0] src_row, tgt_row;
   logic [4:0] src_col, tgt_col;
   logic [3:0] status;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       found;
      logic [9:0] steps;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;

   always #5 clk = ~clk;

   l4_route_ctrl_if #(.NRBITS(5), .NCBITS(5), .NSBITS(10)) ifa ();
   l4_route_ctrl_if #(.NRBITS(6), .NCBITS(5), .NSBITS(10)) ifb ();

   l4_route_ctrl #(.NRBITS(5), .NCBITS(5), .NSBITS(10), .MAXSTEPS(1000)) dut_a (
      .clk(clk), .resetn(resetn), .bus(ifa)
   );
   l4_route_ctrl #(.NRBITS(6), .NCBITS(5), .NSBITS(10), .MAXSTEPS(8)) dut_b (
      .clk(clk), .resetn(resetn), .bus(ifb)
   );

   assign ifa.start      = start & ~sel;
   assign ifb.start      = start & sel;
   assign ifa.abort      = abort;
   assign ifb.abort      = abort;
   assign ifa.src_row    = src_row[4:0];
   assign ifa.tgt_row    = tgt_row[4:0];
   assign ifb.src_row    = src_row;
   assign ifb.tgt_row    = tgt_row;
   assign ifa.src_col    = src_col;
   assign ifa.tgt_col    = tgt_col;
   assign ifb.src_col    = src_col;
   assign ifb.tgt_col    = tgt_col;
   assign ifa.status_out = status;
   assign ifb.status_out = status;

   logic [2:0] o_rsel, o_csel;
   logic [5:0] o_rl;
   logic [4:0] o_cl;
   logic [1:0] o_cmd;
   logic       o_ext, o_ret, o_etch, o_busy, o_done, o_found;
   logic [9:0] o_step;

   assign o_rsel  = sel ? ifb.row_range_sel : ifa.row_range_sel;
   assign o_csel  = sel ? ifb.col_range_sel : ifa.col_range_sel;
   assign o_rl    = sel ? ifb.row_l_v : {1'b0, ifa.row_l_v};
   assign o_cl    = sel ? ifb.col_l_v : ifa.col_l_v;
   assign o_cmd   = sel ? ifb.cell_cmd : ifa.cell_cmd;
   assign o_ext   = sel ? ifb.extend : ifa.extend;
   assign o_ret   = sel ? ifb.ret2ue : ifa.ret2ue;
   assign o_etch  = sel ? ifb.etch_enb : ifa.etch_enb;
   assign o_busy  = sel ? ifb.busy : ifa.busy;
   assign o_done  = sel ? ifb.done : ifa.done;
   assign o_found = sel ? ifb.found : ifa.found;
   assign o_step  = sel ? ifb.step_count : ifa.step_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // scoreboard: every done pulse must match the oldest pending expectation of that instance
   always @(negedge clk) begin
      if (ifa.done === 1'b1) begin
         check("a_done_has_expectation", 32'(q_a.size() != 0), 1);
         if (q_a.size() != 0) begin
            e_a = q_a.pop_front();
            check("a_sb_found", 32'(ifa.found), 32'(e_a.found));
            check("a_sb_steps", 32'(ifa.step_count), 32'(e_a.steps));
         end
      end
      if (ifb.done === 1'b1) begin
         check("b_done_has_expectation", 32'(q_b.size() != 0), 1);
         if (q_b.size() != 0) begin
            e_b = q_b.pop_front();
            check("b_sb_found", 32'(ifb.found), 32'(e_b.found));
            check("b_sb_steps", 32'(ifb.step_count), 32'(e_b.steps));
         end
      end
   end

   task automatic start_route(input logic s, input int sr, input int sc, input int tr, input int tc);
      sel     = s;
      src_row = 6'(sr);
      src_col = 5'(sc);
      tgt_row = 6'(tr);
      tgt_col = 5'(tc);
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // plays the array: raises status bits on chosen expand/trace cycles; returns once busy drops
   task automatic run_route(input int hit_n, input int stall_n, input int trace_n, input int abort_n,
                            input int busy_start_n, output int n_ext, output int n_ret,
                            output int n_etch, output int n_done);
      int ec = 0;
      int tc = 0;
      bit finished = 1'b0;
      n_ext = 0; n_ret = 0; n_etch = 0; n_done = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         status = 4'b0;
         abort  = 1'b0;
         start  = 1'b0;
         if (o_done) n_done++;
         if (!o_busy) begin
            finished = 1'b1;
            break;
         end
         check("strobes_onehot0", 32'($onehot0({o_ext, o_ret, o_etch})), 1);
         if (o_ext) begin
            ec++;
            n_ext++;
            status[0] = (ec == hit_n);
            status[1] = (ec == stall_n);
            abort     = (ec == abort_n);
            start     = (ec == busy_start_n);
         end
         if (o_ret) begin
            tc++;
            n_ret++;
            status[2] = (tc == trace_n);
         end
         if (o_etch) n_etch++;
      end
      status = 4'b0;
      abort  = 1'b0;
      start  = 1'b0;
      check("route_terminates", 32'(finished), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ext, n_ret, n_etch, n_done;
      exp_t e;

      // 1: reset held with start asserted
      resetn = 1'b0; start = 1'b1; abort = 1'b0; sel = 1'b0; status = 4'b0;
      src_row = '0; src_col = '0; tgt_row = '0; tgt_col = '0;
      repeat (3) @(negedge clk);
      check("rst_a_busy", 32'(o_busy), 0);
      check("rst_a_cmd", 32'(o_cmd), 3);
      check("rst_a_rsel", 32'(o_rsel), 0);
      check("rst_a_step", 32'(o_step), 0);
      check("rst_a_strobes", 32'({o_ext, o_ret, o_etch, o_done, o_found}), 0);
      sel = 1'b1;
      #1;
      check("rst_b_busy", 32'(o_busy), 0);
      check("rst_b_cmd", 32'(o_cmd), 3);
      sel = 1'b0;
      resetn = 1'b1; start = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_idle_busy", 32'(o_busy), 0);
      check("post_rst_idle_cmd", 32'(o_cmd), 3);

      // 2: full route (3,4)->(10,4), target on expand cycle 7, trace done on trace cycle 2
      e.found = 1'b1; e.steps = 10'd7; q_a.push_back(e);
      start_route(1'b0, 3, 4, 10, 4);
      check("t2_clear_cmd", 32'(o_cmd), 0);
      check("t2_clear_rsel", 32'(o_rsel), 2);
      check("t2_clear_csel", 32'(o_csel), 2);
      check("t2_clear_busy", 32'(o_busy), 1);
      @(negedge clk);
      check("t2_src_cmd", 32'(o_cmd), 1);
      check("t2_src_rsel", 32'(o_rsel), 1);
      check("t2_src_row", 32'(o_rl), 3);
      check("t2_src_col", 32'(o_cl), 4);
      @(negedge clk);
      check("t2_tgt_cmd", 32'(o_cmd), 2);
      check("t2_tgt_row", 32'(o_rl), 10);
      check("t2_tgt_col", 32'(o_cl), 4);
      run_route(7, 0, 2, 0, 0, n_ext, n_ret, n_etch, n_done);
      check("t2_extend_cycles", 32'(n_ext), 7);
      check("t2_ret2ue_cycles", 32'(n_ret), 2);
      check("t2_etch_cycles", 32'(n_etch), 1);
      check("t2_done_pulses", 32'(n_done), 1);
      check("t2_found_held", 32'(o_found), 1);
      check("t2_steps_held", 32'(o_step), 7);

      // 3: wavefront stall on expand cycle 3
      e.found = 1'b0; e.steps = 10'd3; q_a.push_back(e);
      start_route(1'b0, 5, 6, 20, 21);
      repeat (2) @(negedge clk);
      run_route(0, 3, 0, 0, 0, n_ext, n_ret, n_etch, n_done);
      check("t3_extend_cycles", 32'(n_ext), 3);
      check("t3_no_ret2ue", 32'(n_ret), 0);
      check("t3_no_etch", 32'(n_etch), 0);
      check("t3_done_pulses", 32'(n_done), 1);
      check("t3_found_low", 32'(o_found), 0);

      // 4: timeout on the MAXSTEPS=8 instance
      e.found = 1'b0; e.steps = 10'd8; q_b.push_back(e);
      start_route(1'b1, 40, 2, 50, 3);
      repeat (2) @(negedge clk);
      run_route(0, 0, 0, 0, 0, n_ext, n_ret, n_etch, n_done);
      check("t4_extend_cycles", 32'(n_ext), 8);
      check("t4_done_pulses", 32'(n_done), 1);
      check("t4_steps_sat", 32'(o_step), 8);
      check("t4_found_low", 32'(o_found), 0);

      // 5: abort on expand cycle 5 together with target hit; start while busy ignored
      start_route(1'b0, 1, 2, 3, 4);
      repeat (2) @(negedge clk);
      run_route(5, 0, 1, 5, 2, n_ext, n_ret, n_etch, n_done);
      check("t5_extend_cycles", 32'(n_ext), 5);
      check("t5_no_ret2ue", 32'(n_ret), 0);
      check("t5_no_done", 32'(n_done), 0);
      check("t5_found_low", 32'(o_found), 0);
      check("t5_steps_hold", 32'(o_step), 4);
      check("t5_cmd_nop", 32'(o_cmd), 3);
      check("t5_rsel_none", 32'(o_rsel), 0);
      repeat (3) @(negedge clk);
      check("t5_no_queued_start", 32'(o_busy), 0);
      e.found = 1'b1; e.steps = 10'd2; q_a.push_back(e);
      start_route(1'b0, 1, 1, 2, 2);
      repeat (2) @(negedge clk);
      run_route(2, 0, 1, 0, 0, n_ext, n_ret, n_etch, n_done);
      check("t5_rerun_done", 32'(n_done), 1);
      check("t5_rerun_found", 32'(o_found), 1);

      // 6: src == tgt at the array corner, both instances
      for (int k = 0; k < 2; k++) begin
         e.found = 1'b1; e.steps = 10'd1;
         if (k == 0) q_a.push_back(e); else q_b.push_back(e);
         start_route(k[0], 31, 31, 31, 31);
         @(negedge clk);
         check("t6_src_row_31", 32'(o_rl), 31);
         check("t6_src_col_31", 32'(o_cl), 31);
         check("t6_src_cmd", 32'(o_cmd), 1);
         @(negedge clk);
         run_route(1, 0, 1, 0, 0, n_ext, n_ret, n_etch, n_done);
         check("t6_extend_cycles", 32'(n_ext), 1);
         check("t6_steps", 32'(o_step), 1);
         check("t6_found", 32'(o_found), 1);
      end

      repeat (2) @(negedge clk);
      check("sb_a_drained", 32'(q_a.size()), 0);
      check("sb_b_drained", 32'(q_b.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
